// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch
// Description : Instruction fetch stage in front of the memory controller.
//               Generates sequential fetch addresses, issues one 4-byte read
//               at a time over the rw_if/status_if handshake, optionally
//               takes single-cycle hits from the instruction cache, and
//               buffers fetched words in a small FIFO for decode. A branch
//               redirect flushes the FIFO and any read in flight.
// Build macro : IFETCH_CACHE_EN - when defined, cache_hit_i/cache_val_i are
//               honoured in IDLE; when undefined they are ignored and every
//               fetch goes through the memory controller.
// Ports       : clk, rst (sync, active-high), rdy (global freeze when low)
//               branch_flag_i/branch_tgt_i  - redirect from EX
//               inst_valid_o/inst_o/inst_pc_o/inst_ready_i - decode handshake
//               pc_o                        - cache lookup / fill address
//               rw_if_o/addr_if_o/status_if_i/inst_data_i - mem ctrl read
//               cache_hit_i/cache_val_i     - cache hit for pc_o
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch #(
    parameter int          QUEUE_DEPTH = 4,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_tgt_i,
    input  logic        inst_ready_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    output logic [31:0] pc_o,
    output logic        rw_if_o,
    output logic [31:0] addr_if_o,
    input  logic [1:0]  status_if_i,
    input  logic [31:0] inst_data_i,
    input  logic        cache_hit_i,
    input  logic [31:0] cache_val_i
);

    localparam int                 c_PTR_W    = $clog2(QUEUE_DEPTH);
    localparam int                 c_CNT_W    = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(QUEUE_DEPTH);

    localparam logic [1:0] c_STAT_WORKING = 2'd1;
    localparam logic [1:0] c_STAT_DONE    = 2'd2;

    localparam logic [2:0] c_S_IDLE    = 3'd0;
    localparam logic [2:0] c_S_REQ     = 3'd1;
    localparam logic [2:0] c_S_WAIT    = 3'd2;
    localparam logic [2:0] c_S_DRAIN   = 3'd3;
    localparam logic [2:0] c_S_DISCARD = 3'd4;

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [31:0]        r_fpc;
    logic [31:0]        r_req_pc;
    logic [31:0]        r_q_inst [QUEUE_DEPTH];
    logic [31:0]        r_q_pc   [QUEUE_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic        w_full;
    logic        w_empty;
    logic        w_pop;
    logic        w_working;
    logic        w_done;
    logic        w_hit;
    logic [31:0] w_hit_val;
    logic        w_push;
    logic [31:0] w_push_pc;
    logic [31:0] w_push_inst;
    logic        w_issue;
    logic [31:0] w_fpc_nxt;

`ifdef IFETCH_CACHE_EN
    assign w_hit     = cache_hit_i;
    assign w_hit_val = cache_val_i;
`else
    assign w_hit     = 1'b0;
    assign w_hit_val = 32'h0000_0000;
    logic w_unused_cache;
    assign w_unused_cache = ^{cache_hit_i, cache_val_i};
`endif

    assign w_working = (status_if_i == c_STAT_WORKING);
    assign w_done    = (status_if_i == c_STAT_DONE);
    // Full is taken from the registered count, i.e. before this cycle's pop.
    assign w_full    = (r_count == c_FULL_CNT);
    assign w_empty   = (r_count == '0);

    // A redirect hides the stale head from decode in the same cycle.
    assign inst_valid_o = !w_empty && !branch_flag_i;
    assign w_pop        = inst_valid_o && inst_ready_i;
    assign inst_o       = r_q_inst[r_rd_ptr];
    assign inst_pc_o    = r_q_pc[r_rd_ptr];
    assign addr_if_o    = r_req_pc;

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_IDLE;
        end else if (rdy) begin
            r_state <= w_state_nxt;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (!branch_flag_i && !w_full && !w_hit) begin
                    w_state_nxt = c_S_REQ;
                end
            end
            c_S_REQ: begin
                // Redirect before acceptance: one cycle in DRAIN tells us
                // whether the controller took the request on this edge.
                if (branch_flag_i) begin
                    w_state_nxt = c_S_DRAIN;
                end else if (w_working) begin
                    w_state_nxt = c_S_WAIT;
                end
            end
            c_S_WAIT: begin
                // DONE together with a redirect drops the data and ends here.
                if (w_done) begin
                    w_state_nxt = c_S_IDLE;
                end else if (branch_flag_i) begin
                    w_state_nxt = c_S_DISCARD;
                end
            end
            c_S_DRAIN: begin
                w_state_nxt = w_working ? c_S_DISCARD : c_S_IDLE;
            end
            c_S_DISCARD: begin
                if (w_done) begin
                    w_state_nxt = c_S_IDLE;
                end
            end
            default: w_state_nxt = c_S_IDLE;
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        rw_if_o     = (r_state == c_S_REQ);
        // The fill on the DONE cycle must be tagged with the requested PC.
        pc_o        = (r_state == c_S_IDLE) ? r_fpc : r_req_pc;
        w_issue     = 1'b0;
        w_push      = 1'b0;
        w_push_pc   = r_req_pc;
        w_push_inst = inst_data_i;
        w_fpc_nxt   = r_fpc;
        if (branch_flag_i) begin
            w_fpc_nxt = branch_tgt_i;
        end else if (r_state == c_S_IDLE && !w_full) begin
            if (w_hit) begin
                w_push      = 1'b1;
                w_push_pc   = r_fpc;
                w_push_inst = w_hit_val;
                w_fpc_nxt   = r_fpc + 32'd4;
            end else begin
                w_issue = 1'b1;
            end
        end else if (r_state == c_S_WAIT && w_done) begin
            w_push    = 1'b1;
            w_fpc_nxt = r_req_pc + 32'd4;
        end
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fpc    <= RESET_PC;
            r_req_pc <= 32'h0000_0000;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (rdy) begin
            r_fpc <= w_fpc_nxt;
            if (w_issue) begin
                r_req_pc <= r_fpc;
            end
            if (branch_flag_i) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + c_CNT_W'(1);
                    2'b01:   r_count <= r_count - c_CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Storage needs no reset; validity is carried by r_count.
    always_ff @(posedge clk) begin
        if (rdy && !rst && w_push) begin
            r_q_inst[r_wr_ptr] <= w_push_inst;
            r_q_pc[r_wr_ptr]   <= w_push_pc;
        end
    end

endmodule
`default_nettype wire
